// File: rtl/sfu_seq_array.sv
// sfu_seq_array: special-function lanes plus a small sequencer that walks a run
// of PSUM rows through a single-port SRAM, either rewriting each row in place
// (pass / ReLU) or reducing the run into one saturated row written to dst_addr.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; job parameters latched on an accepted start
// RD    | read strobe for source row base+row
// PROC  | read data present; lanes updated (f(x) or saturating add)
// WR    | write f(x) back to the row just read (pass / ReLU jobs)
// FIN   | write the reduced row to dst_addr (accumulate jobs)
// DONE  | one-cycle done pulse, then back to IDLE
module sfu_seq_array #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int ADDR_W  = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [ADDR_W:0]          len,
    input  logic [ADDR_W-1:0]        dst_addr,
    input  logic [col*psum_bw-1:0]   mem_rd_data,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_rd_en,
    output logic                     mem_wr_en,
    output logic [col*psum_bw-1:0]   mem_wr_data,
    output logic                     busy,
    output logic                     done,
    output logic                     sat
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_PROC,
        S_WR,
        S_FIN,
        S_DONE
    } state_t;

    localparam logic signed [psum_bw-1:0] LANE_MAX = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic signed [psum_bw-1:0] LANE_MIN = {1'b1, {(psum_bw-1){1'b0}}};

    state_t                      state_q;
    state_t                      state_d;
    logic [1:0]                  mode_q;
    logic [ADDR_W-1:0]           base_q;
    logic [ADDR_W-1:0]           dst_q;
    logic [ADDR_W:0]             len_q;
    logic [ADDR_W:0]             row_q;
    logic [ADDR_W:0]             row_inc;
    logic                        row_last;
    logic [ADDR_W-1:0]           src_addr;
    logic                        sat_q;

    // lane_q holds f(x) for pass/ReLU jobs and the running sum for accumulate jobs
    logic signed [psum_bw-1:0]   lane_q   [col];
    logic signed [psum_bw-1:0]   lane_d   [col];
    logic signed [psum_bw-1:0]   rd_lane  [col];
    logic signed [psum_bw-1:0]   out_lane [col];
    logic signed [psum_bw:0]     sum_w    [col];
    logic [col-1:0]              lane_sat;

    assign row_inc  = row_q + {{ADDR_W{1'b0}}, 1'b1};
    assign row_last = (row_inc == len_q);
    assign src_addr = base_q + row_q[ADDR_W-1:0];

    // Per-lane function: pass/ReLU of fresh data, or saturating accumulate.
    // A one-bit-wider sum overflows exactly when its top two bits disagree.
    always_comb begin
        lane_sat = '0;
        for (int i = 0; i < col; i++) begin
            rd_lane[i]  = mem_rd_data[i*psum_bw +: psum_bw];
            sum_w[i]    = {lane_q[i][psum_bw-1], lane_q[i]} + {rd_lane[i][psum_bw-1], rd_lane[i]};
            lane_sat[i] = sum_w[i][psum_bw] ^ sum_w[i][psum_bw-1];
            if (mode_q[1]) begin
                if (lane_sat[i])
                    lane_d[i] = sum_w[i][psum_bw] ? LANE_MIN : LANE_MAX;
                else
                    lane_d[i] = sum_w[i][psum_bw-1:0];
            end else begin
                lane_d[i] = (mode_q[0] && rd_lane[i][psum_bw-1]) ? '0 : rd_lane[i];
            end
            // ReLU on the final sum only for accumulate+ReLU; pass/ReLU lanes are already final
            out_lane[i] = (mode_q[1] && mode_q[0] && lane_q[i][psum_bw-1]) ? '0 : lane_q[i];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start)
                    state_d = (len == '0) ? S_DONE : S_RD;
            end
            S_RD:   state_d = S_PROC;
            S_PROC: begin
                if (mode_q[1])
                    state_d = row_last ? S_FIN : S_RD;
                else
                    state_d = S_WR;
            end
            S_WR:   state_d = row_last ? S_DONE : S_RD;
            S_FIN:  state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Job parameters, row counter, lane registers and sticky saturation flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= '0;
            base_q <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            row_q  <= '0;
            sat_q  <= 1'b0;
            for (int i = 0; i < col; i++)
                lane_q[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        base_q <= base_addr;
                        dst_q  <= dst_addr;
                        len_q  <= len;
                        row_q  <= '0;
                        sat_q  <= 1'b0;
                        for (int i = 0; i < col; i++)
                            lane_q[i] <= '0;
                    end
                end
                S_PROC: begin
                    for (int i = 0; i < col; i++)
                        lane_q[i] <= lane_d[i];
                    if (mode_q[1]) begin
                        row_q <= row_inc;
                        if (|lane_sat)
                            sat_q <= 1'b1;
                    end
                end
                S_WR: row_q <= row_inc;
                default: ;
            endcase
        end
    end

    // Memory strobes and handshake; everything forced low while reset is held
    // so an abort issues no access in the reset cycle itself.
    always_comb begin
        mem_addr    = '0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        busy        = 1'b0;
        done        = 1'b0;
        sat         = sat_q;
        case (state_q)
            S_RD: begin
                mem_rd_en = 1'b1;
                mem_addr  = src_addr;
                busy      = 1'b1;
            end
            S_PROC: busy = 1'b1;
            S_WR: begin
                mem_wr_en = 1'b1;
                mem_addr  = src_addr;
                busy      = 1'b1;
                for (int i = 0; i < col; i++)
                    mem_wr_data[i*psum_bw +: psum_bw] = out_lane[i];
            end
            S_FIN: begin
                mem_wr_en = 1'b1;
                mem_addr  = dst_q;
                busy      = 1'b1;
                for (int i = 0; i < col; i++)
                    mem_wr_data[i*psum_bw +: psum_bw] = out_lane[i];
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
        if (reset) begin
            mem_addr    = '0;
            mem_rd_en   = 1'b0;
            mem_wr_en   = 1'b0;
            mem_wr_data = '0;
            busy        = 1'b0;
            done        = 1'b0;
            sat         = 1'b0;
        end
    end

endmodule

// File: tb/tb_sfu_seq_array.sv
// Bench for sfu_seq_array: a schedule model fills per-cycle expected outputs
// from the job timing rules, one compare process checks them every cycle,
// and hand-computed literals pin the model's results.
module tb_sfu_seq_array;

    localparam int COL  = 8;
    localparam int BW   = 16;
    localparam int AW   = 11;
    localparam int DW   = COL*BW;
    localparam int NROW = 2**AW;
    localparam int MAXC = 1024;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [1:0]     mode = '0;
    logic [AW-1:0]  base_addr = '0;
    logic [AW:0]    len = '0;
    logic [AW-1:0]  dst_addr = '0;
    logic [DW-1:0]  mem_rd_data = '0;
    logic [AW-1:0]  mem_addr;
    logic           mem_rd_en;
    logic           mem_wr_en;
    logic [DW-1:0]  mem_wr_data;
    logic           busy;
    logic           done;
    logic           sat;

    sfu_seq_array #(.col(COL), .psum_bw(BW), .ADDR_W(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mode        (mode),
        .base_addr   (base_addr),
        .len         (len),
        .dst_addr    (dst_addr),
        .mem_rd_data (mem_rd_data),
        .mem_addr    (mem_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data),
        .busy        (busy),
        .done        (done),
        .sat         (sat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model with one-cycle read latency; bench preloads through the same port
    logic [DW-1:0]  mem [NROW];
    logic           pre_we = 1'b0;
    logic [AW-1:0]  pre_addr = '0;
    logic [DW-1:0]  pre_data = '0;
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    // expected outputs per cycle index (cycle c = interval after the c-th rising edge)
    bit            exp_rd   [MAXC];
    bit            exp_wr   [MAXC];
    bit            exp_busy [MAXC];
    bit            exp_done [MAXC];
    bit            exp_sat  [MAXC];
    bit [AW-1:0]   exp_addr [MAXC];
    bit [DW-1:0]   exp_wd   [MAXC];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, expv);
        end
    endtask

    function automatic int lane(input logic [DW-1:0] d, input int i);
        logic signed [BW-1:0] v;
        v = d[i*BW +: BW];
        return int'(v);
    endfunction

    function automatic logic [DW-1:0] mk(input int l0, input int l1, input int l2, input int l3,
                                         input int l4, input int l5, input int l6, input int l7);
        int l [COL];
        logic [DW-1:0] r;
        l = '{l0, l1, l2, l3, l4, l5, l6, l7};
        r = '0;
        for (int i = 0; i < COL; i++) r[i*BW +: BW] = l[i][BW-1:0];
        return r;
    endfunction

    task automatic clear_from(input int c0);
        for (int c = c0; c < MAXC; c++) begin
            exp_rd[c] = 0; exp_wr[c] = 0; exp_busy[c] = 0; exp_done[c] = 0;
            exp_sat[c] = 0; exp_addr[c] = '0; exp_wd[c] = '0;
        end
    endtask

    // Job model: timing from the row formulas, data from the bench memory image
    task automatic plan_job(input int t, input logic [1:0] m, input int base, input int n, input int dst);
        int acc [COL];
        int v;
        int a;
        int c;
        bit sflag;
        logic [DW-1:0] w;
        for (int cc = t + 1; cc < MAXC; cc++) exp_sat[cc] = 0;
        if (n == 0) begin
            exp_done[t+1] = 1;
            return;
        end
        if (!m[1]) begin
            for (int k = 0; k < n; k++) begin
                a = (base + k) % NROW;
                c = t + 1 + 3*k;
                exp_rd[c] = 1; exp_addr[c] = a[AW-1:0]; exp_busy[c] = 1;
                exp_busy[c+1] = 1;
                w = '0;
                for (int i = 0; i < COL; i++) begin
                    v = lane(mem[a], i);
                    if (m[0] && v < 0) v = 0;
                    w[i*BW +: BW] = v[BW-1:0];
                end
                exp_wr[c+2] = 1; exp_addr[c+2] = a[AW-1:0]; exp_busy[c+2] = 1; exp_wd[c+2] = w;
            end
            exp_done[t+1+3*n] = 1;
        end else begin
            sflag = 0;
            for (int i = 0; i < COL; i++) acc[i] = 0;
            for (int k = 0; k < n; k++) begin
                a = (base + k) % NROW;
                c = t + 1 + 2*k;
                exp_rd[c] = 1; exp_addr[c] = a[AW-1:0]; exp_busy[c] = 1;
                exp_busy[c+1] = 1;
                for (int i = 0; i < COL; i++) begin
                    acc[i] = acc[i] + lane(mem[a], i);
                    if (acc[i] > 32767)  begin acc[i] = 32767;  sflag = 1; end
                    if (acc[i] < -32768) begin acc[i] = -32768; sflag = 1; end
                end
                if (sflag)
                    for (int cc = c + 2; cc < MAXC; cc++) exp_sat[cc] = 1;
            end
            w = '0;
            for (int i = 0; i < COL; i++) begin
                v = (m[0] && acc[i] < 0) ? 0 : acc[i];
                w[i*BW +: BW] = v[BW-1:0];
            end
            c = t + 1 + 2*n;
            exp_wr[c] = 1; exp_addr[c] = dst[AW-1:0]; exp_busy[c] = 1; exp_wd[c] = w;
            exp_done[c+1] = 1;
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (cyc < MAXC) begin
            chk("rd_en",   DW'(mem_rd_en), DW'(exp_rd[cyc]));
            chk("wr_en",   DW'(mem_wr_en), DW'(exp_wr[cyc]));
            chk("addr",    DW'(mem_addr),  DW'(exp_addr[cyc]));
            chk("wr_data", mem_wr_data,    exp_wd[cyc]);
            chk("busy",    DW'(busy),      DW'(exp_busy[cyc]));
            chk("done",    DW'(done),      DW'(exp_done[cyc]));
            chk("sat",     DW'(sat),       DW'(exp_sat[cyc]));
            chk("excl",    DW'(mem_rd_en & mem_wr_en), '0);
        end
    end

    // Event log used by the literal pins
    int done_q [$];
    int rd_q [$];
    int strobe_cnt = 0;
    always @(negedge clk) begin
        if (done) done_q.push_back(cyc);
        if (mem_rd_en) rd_q.push_back(int'(mem_addr));
        if (mem_rd_en || mem_wr_en) strobe_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_row(input int a, input logic [DW-1:0] d);
        pre_addr = a[AW-1:0];
        pre_data = d;
        pre_we   = 1'b1;
        tick();
        pre_we   = 1'b0;
    endtask

    task automatic start_job(input logic [1:0] m, input int b, input int n, input int d, output int t);
        mode      = m;
        base_addr = b[AW-1:0];
        len       = n[AW:0];
        dst_addr  = d[AW-1:0];
        start     = 1'b1;
        t         = cyc;
        plan_job(t, m, b, n, d);
        tick();
        start     = 1'b0;
        mode      = ~m;
        base_addr = 11'd1234;
        len       = 12'd5;
        dst_addr  = 11'd777;
    endtask

    int t;
    int nd;
    int nr;
    int ns;

    initial begin
        repeat (3) tick();
        reset = 1'b0;

        load_row(4,    mk(-3, 5, 0, -32768, 7, -1, 100, 2));
        load_row(5,    mk(-3, 5, 0, -32768, 7, -1, 100, 2));
        load_row(10,   mk(30000, 1, -20000, 0, 0, 0, 0, 0));
        load_row(11,   mk(30000, 2, -20000, 0, 0, 0, 0, 0));
        load_row(12,   mk(-5, 3, -5, 0, 0, 0, 0, 0));
        load_row(13,   mk(1, 1, 1, 1, 1, 1, 1, 1));
        load_row(20,   mk(-10, 4, 0, 0, 0, 0, 0, 0));
        load_row(21,   mk(3, 5, 0, 0, 0, 0, 0, 0));
        load_row(2046, mk(100, -200, 300, -400, 1, 2, 3, 4));
        load_row(2047, mk(-1, -2, -3, -4, 5, 6, 7, 8));
        load_row(0,    mk(11, 22, 33, 44, 55, 66, 77, 88));
        load_row(1,    mk(-32768, 32767, 0, 1, -1, 9, 8, 7));
        tick();

        // ReLU rewrite of rows 4..5
        nd = done_q.size();
        start_job(2'b01, 4, 2, 0, t);
        repeat (9) tick();
        chk("m01_done_cnt", DW'(done_q.size() - nd), DW'(1));
        chk("m01_done_cyc", DW'(done_q[$]), DW'(t + 7));
        chk("m01_row4", mem[4], mk(0, 5, 0, 0, 7, 0, 100, 2));
        chk("m01_row5", mem[5], mk(0, 5, 0, 0, 7, 0, 100, 2));

        // Saturating accumulate of rows 10..12
        nd = done_q.size();
        start_job(2'b10, 10, 3, 100, t);
        repeat (10) tick();
        chk("m10_done_cyc", DW'(done_q[$]), DW'(t + 8));
        chk("m10_lane0", DW'(lane(mem[100], 0)), DW'(32762));
        chk("m10_lane1", DW'(lane(mem[100], 1)), DW'(6));
        chk("m10_lane2", DW'(lane(mem[100], 2)), DW'(-32768));
        chk("m10_sat", DW'(sat), DW'(1));

        // Accumulate + ReLU, destination inside the source run
        start_job(2'b11, 20, 2, 21, t);
        repeat (8) tick();
        chk("m11_done_cyc", DW'(done_q[$]), DW'(t + 6));
        chk("m11_lane0", DW'(lane(mem[21], 0)), DW'(0));
        chk("m11_lane1", DW'(lane(mem[21], 1)), DW'(9));
        chk("m11_sat", DW'(sat), DW'(0));

        // Address wrap-around
        nr = rd_q.size();
        start_job(2'b00, 2046, 4, 0, t);
        repeat (15) tick();
        chk("wrap_nrd", DW'(rd_q.size() - nr), DW'(4));
        chk("wrap_a0", DW'(rd_q[nr]),   DW'(2046));
        chk("wrap_a1", DW'(rd_q[nr+1]), DW'(2047));
        chk("wrap_a2", DW'(rd_q[nr+2]), DW'(0));
        chk("wrap_a3", DW'(rd_q[nr+3]), DW'(1));
        chk("wrap_row0", mem[0], mk(11, 22, 33, 44, 55, 66, 77, 88));

        // Zero-length job
        ns = strobe_cnt;
        start_job(2'b10, 300, 0, 5, t);
        repeat (4) tick();
        chk("len0_done_cyc", DW'(done_q[$]), DW'(t + 1));
        chk("len0_strobes", DW'(strobe_cnt - ns), DW'(0));

        // start while busy is ignored
        nd = done_q.size();
        start_job(2'b10, 10, 3, 100, t);
        tick(); tick();
        mode = 2'b00; len = '0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        chk("busy_start_cnt", DW'(done_q.size() - nd), DW'(1));
        chk("busy_start_cyc", DW'(done_q[$]), DW'(t + 8));

        // Reset during the second read of a 4-row job
        nd = done_q.size();
        start_job(2'b10, 10, 4, 200, t);
        tick();
        tick();
        reset = 1'b1;
        clear_from(cyc);
        ns = strobe_cnt;
        tick();
        reset = 1'b0;
        chk("rst_busy", DW'(busy), '0);
        chk("rst_sat", DW'(sat), '0);
        repeat (8) tick();
        chk("rst_strobes", DW'(strobe_cnt - ns), DW'(0));
        chk("rst_done_cnt", DW'(done_q.size() - nd), DW'(0));

        // Fresh job after the abort
        start_job(2'b01, 4, 2, 0, t);
        repeat (9) tick();
        chk("post_rst_done", DW'(done_q[$]), DW'(t + 7));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sfu_seq_array.md
# sfu_seq_array

Parameterised special-function array with an integrated sequencer for the PSUM SRAM. On a `start` pulse it walks a programmable run of PSUM rows, applies a per-job function (pass, ReLU, saturating row-accumulate, accumulate+ReLU) to all `col` lanes in parallel, and writes results back through a single-port SRAM interface. It sits between the PE array's PSUM memory and the output stage. Compared with the fixed-op SFU array, it adds a variable job length, a base address and a destination address, row reduction, saturation detection, and a done handshake.

## Interface
- `col`, 8, lane count (one lane per output channel)
- `psum_bw`, 16, signed lane width
- `ADDR_W`, 11, PSUM SRAM address width
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  job request pulse; sampled only in IDLE
- `mode`  in  2  00 pass, 01 ReLU, 10 accumulate, 11 accumulate+ReLU; latched at start
- `base_addr`  in  ADDR_W  first source row
- `len`  in  ADDR_W+1  rows in job (0..2^ADDR_W)
- `dst_addr`  in  ADDR_W  result row for modes 1x; latched at start
- `mem_rd_data`  in  col*psum_bw  SRAM read data; valid the cycle after `mem_rd_en`
- `mem_addr`  out  ADDR_W  SRAM address
- `mem_rd_en`  out  1  read strobe
- `mem_wr_en`  out  1  write strobe; never high together with `mem_rd_en`
- `mem_wr_data`  out  col*psum_bw  write data, lane i at bits [(i+1)*psum_bw-1 : i*psum_bw]
- `busy`  out  1  high from the cycle after an accepted start until DONE
- `done`  out  1  one-cycle pulse at job end
- `sat`  out  1  sticky: some lane saturated in this job; cleared on accepted start

## Operation
- States: IDLE, RD, PROC, WR, FIN, DONE.
- IDLE:
  - `start` with `len`≠0: latch mode, addresses and len; clear row counter, accumulators and `sat`; go to RD.
  - `start` with `len`=0: go directly to DONE (no memory access, `sat` cleared).
- RD: `mem_rd_en`=1, `mem_addr`=base_addr+row (mod 2^ADDR_W). Always goes to PROC.
- PROC: capture `mem_rd_data`.
  - Modes 0x: lane register = f(data), where f = identity (00) or max(x,0) (01); go to WR.
  - Modes 1x: acc_i = sat(acc_i + x_i); row++; if row==len go to FIN, else RD.
- WR (modes 0x): `mem_wr_en`=1, `mem_addr` = the same row that was read, `mem_wr_data` = lane registers; row++; if row==len go to DONE, else RD.
- FIN (modes 1x): `mem_wr_en`=1, `mem_addr`=dst_addr, `mem_wr_data` = acc (mode 10) or max(acc,0) per lane (mode 11); go to DONE.
- DONE: `done`=1, `busy`=0; go to IDLE.
- Arithmetic and boundary behaviour:
  - Each lane is a signed psum_bw two's-complement value.
  - Accumulation saturates to +2^(psum_bw-1)-1 / -2^(psum_bw-1), and saturation sets `sat`.
  - ReLU in mode 11 acts on the saturated sum.
  - Address arithmetic wraps modulo 2^ADDR_W.
  - `start` outside IDLE is ignored; the job is not restarted.
  - `dst_addr` may lie inside the source range; the write happens after all reads.
- Inputs `mode`, `base_addr`, `len` and `dst_addr` may change freely after start.

## Timing
- Reset: state IDLE, all outputs 0 (`mem_addr`, `mem_wr_data`, `busy`, `done`, `sat`, strobes), accumulators 0.
- Reset asserted mid-job aborts the job the same cycle: no strobe is issued in that cycle, and no `done` pulse.
- Memory read latency is fixed at 1 cycle.
- Start accepted at cycle T.
- Modes 0x:
  - RD of row k at T+1+3k; write of row k at T+3+3k.
  - `done` at T+1+3·len.
- Modes 1x:
  - RD of row k at T+1+2k.
  - FIN write at T+1+2·len; `done` at T+2+2·len.
- len=0: `done` at T+1.
- `busy`=1 in every RD/PROC/WR/FIN cycle.
- A new start is accepted in the cycle after `done` (IDLE).

## Test plan
- Mode 01, col=8, base=4, len=2, rows hold lanes {-3,5,0,-32768,7,-1,100,2}: writes to 4 and 5 carry {0,5,0,0,7,0,100,2}; `done` at T+7; the strobes are never both high.
- Mode 10, len=3, lane 0 values 30000, 30000, -5: saturation makes lane 0 = 32767 after row 2 and 32762 after row 3; result 32762 written to dst_addr; `sat`=1; `done` at T+8.
- Mode 11, len=2, lane values -10 and 3: dst lane = 0; any lane summing to +9 writes 9; `sat`=0.
- Wrap-around: base=2046, len=4, ADDR_W=11: read addresses 2046, 2047, 0, 1.
- len=0 gives `done` at T+1 with no strobes. A `start` during busy is ignored, and the original job completes with unchanged timing.
- Reset asserted at the cycle of the second RD in a len=4 job: no further strobes and no `done`. All outputs are 0 next cycle, and a fresh start runs normally.
